// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM latch controls into a req/ack data-memory
// transaction, aligns store lanes, extracts/extends loads, stalls and resolves branches.
module mem_access_unit #(
    parameter int BITS_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic [BITS_SIZE-1:0] i_alu,
    input  logic [BITS_SIZE-1:0] i_register_2,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_size_filter,
    input  logic [1:0]           i_size_filterL,
    input  logic                 i_zero_extend,
    input  logic                 i_branch,
    input  logic                 i_neq_branch,
    input  logic                 i_zero,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [BITS_SIZE-1:0] o_dmem_addr,
    output logic [BITS_SIZE-1:0] o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic                 i_dmem_ack,
    input  logic [BITS_SIZE-1:0] i_dmem_rdata,
    output logic [BITS_SIZE-1:0] o_load_data,
    output logic                 o_load_valid,
    output logic                 o_stall,
    output logic                 o_pc_src,
    output logic                 o_misaligned,
    output logic                 o_timeout,
    output logic [1:0]           o_state
);

    // Memory handshake: o_dmem_req stays high, with we/addr/wdata/be stable, from
    // the first ACCESS cycle until the cycle i_dmem_ack is seen high; rdata is
    // valid in that same cycle and the request drops on the following edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      size_sel;
    logic            access_req, aligned, pending;
    logic            req, stall, load_valid, timeout;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [BITS_SIZE-1:0] ld_ext;
    logic [3:0]      be;
    logic [BITS_SIZE-1:0] wdata;

    // A store wins when both read and write are requested.
    assign access_req = i_mem_read | i_mem_write;
    assign size_sel   = i_mem_write ? i_size_filter : i_size_filterL;

    always_comb begin
        aligned = 1'b0;
        case (size_sel)
            2'b10:   aligned = 1'b1;
            2'b01:   aligned = ~i_alu[0];
            default: aligned = (i_alu[1:0] == 2'b00);
        endcase
    end

    assign pending = access_req & aligned;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req        = 1'b0;
        stall      = 1'b0;
        load_valid = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                stall = pending & i_step;
                if (i_step && pending) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                end
            end
            ACCESS: begin
                req   = 1'b1;
                stall = 1'b1;
                if (i_dmem_ack) begin
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ERROR;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                load_valid = 1'b1;
                if (i_step) state_next = IDLE;
            end
            ERROR: begin
                stall   = 1'b1;
                timeout = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Store lane placement, little-endian.
    always_comb begin
        be    = 4'hF;
        wdata = i_register_2;
        if (i_mem_write) begin
            case (i_size_filter)
                2'b10: begin
                    be    = 4'b0001 << i_alu[1:0];
                    wdata = {(BITS_SIZE/8){i_register_2[7:0]}};
                end
                2'b01: begin
                    be    = i_alu[1] ? 4'b1100 : 4'b0011;
                    wdata = {(BITS_SIZE/16){i_register_2[15:0]}};
                end
                default: begin
                    be    = 4'hF;
                    wdata = i_register_2;
                end
            endcase
        end
    end

    assign ld_byte = i_dmem_rdata[{i_alu[1:0], 3'b000} +: 8];
    assign ld_half = i_dmem_rdata[{i_alu[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = i_dmem_rdata;
        case (i_size_filterL)
            2'b10: ld_ext = i_zero_extend ? {{(BITS_SIZE-8){1'b0}}, ld_byte}
                                          : {{(BITS_SIZE-8){ld_byte[7]}}, ld_byte};
            2'b01: ld_ext = i_zero_extend ? {{(BITS_SIZE-16){1'b0}}, ld_half}
                                          : {{(BITS_SIZE-16){ld_half[15]}}, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_load_data  <= '0;
            o_misaligned <= 1'b0;
        end else begin
            if (state == ACCESS && i_dmem_ack && !i_mem_write) o_load_data <= ld_ext;
            if (state == IDLE && i_step && access_req && !aligned) o_misaligned <= 1'b1;
        end
    end

    // Combinational outputs are gated by reset so everything reads low while it is held.
    assign o_dmem_req   = i_reset & req;
    assign o_dmem_we    = i_reset & req & i_mem_write;
    assign o_dmem_addr  = i_reset ? {i_alu[BITS_SIZE-1:2], 2'b00} : '0;
    assign o_dmem_wdata = i_reset ? wdata : '0;
    assign o_dmem_be    = i_reset ? be : 4'h0;
    assign o_load_valid = i_reset & load_valid;
    assign o_stall      = i_reset & stall;
    assign o_timeout    = i_reset & timeout;
    assign o_pc_src     = i_reset & (state != ERROR) &
                          ((i_branch & i_zero) | (i_neq_branch & ~i_zero));
    assign o_state      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions scored against a specification-level model.
module tb_mem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_step = 1'b0;
    logic [31:0] i_alu = '0, i_register_2 = '0, i_dmem_rdata = '0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [1:0]  i_size_filter = '0, i_size_filterL = '0;
    logic        i_zero_extend = 1'b0, i_branch = 1'b0, i_neq_branch = 1'b0, i_zero = 1'b0;
    logic        i_dmem_ack = 1'b0;
    logic        o_dmem_req, o_dmem_we, o_load_valid, o_stall, o_pc_src, o_misaligned, o_timeout;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_load_data;
    logic [3:0]  o_dmem_be;
    logic [1:0]  o_state;

    int checks = 0;
    int fails  = 0;
    logic [31:0] model_ld = '0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.BITS_SIZE(32), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_alu(i_alu),
        .i_register_2(i_register_2), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_size_filter(i_size_filter), .i_size_filterL(i_size_filterL),
        .i_zero_extend(i_zero_extend), .i_branch(i_branch), .i_neq_branch(i_neq_branch),
        .i_zero(i_zero), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_load_data(o_load_data),
        .o_load_valid(o_load_valid), .o_stall(o_stall), .o_pc_src(o_pc_src),
        .o_misaligned(o_misaligned), .o_timeout(o_timeout), .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(bit wr, logic [31:0] a, logic [1:0] sz);
        if (!wr) return 4'hF;
        if (sz == 2'b10) return 4'(1 << (a % 4));
        if (sz == 2'b01) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] d, logic [1:0] sz);
        if (sz == 2'b10) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] rd, logic [31:0] a, logic [1:0] sz, bit zext);
        logic [31:0] v;
        if (sz == 2'b10) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!zext && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'b01) begin
            v = ((a % 4) >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
            if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    function automatic bit m_pc(bit b, bit n, bit z);
        return (b && z) || (n && !z);
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one aligned access in IDLE and acks it after `delay` ACCESS cycles;
    // returns at the negedge of the first DONE cycle.
    task automatic drive_access(input bit wr, input logic [31:0] addr, data, rdata,
                                input logic [1:0] sz, input bit zext, input int delay,
                                output int stall_cyc, output int req_cyc,
                                output logic [3:0] be_s, output logic [31:0] wd_s, ad_s,
                                output logic we_s);
        @(negedge i_clk);
        i_alu = addr; i_register_2 = data; i_zero_extend = zext;
        i_mem_write = wr; i_mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        i_size_filter  = wr ? sz : 2'($urandom_range(0, 3));
        i_size_filterL = wr ? 2'($urandom_range(0, 3)) : sz;
        i_step = 1'b1; i_dmem_ack = 1'b0;
        #1 stall_cyc = int'(o_stall);
        req_cyc = 0; be_s = '0; wd_s = '0; ad_s = '0; we_s = 1'b0;
        for (int c = 0; c <= delay; c++) begin
            @(negedge i_clk);
            i_step = 1'b0;
            i_dmem_ack = (c == delay);
            i_dmem_rdata = (c == delay) ? rdata : $urandom;
            #1;
            stall_cyc += int'(o_stall);
            req_cyc   += int'(o_dmem_req);
            if (c == 0) begin
                be_s = o_dmem_be; wd_s = o_dmem_wdata; ad_s = o_dmem_addr; we_s = o_dmem_we;
            end
        end
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
    endtask

    // Holds DONE for `hold` cycles with i_step low, steps out, retires the instruction.
    task automatic finish_done(input int hold, output int valid_cnt, output int req_cnt);
        valid_cnt = 0; req_cnt = 0;
        for (int h = 0; h < hold; h++) begin
            #1 valid_cnt += int'(o_load_valid); req_cnt += int'(o_dmem_req);
            @(negedge i_clk);
        end
        i_step = 1'b1;
        #1 valid_cnt += int'(o_load_valid);
        @(negedge i_clk);
        i_mem_read = 1'b0; i_mem_write = 1'b0;
        #1 req_cnt += int'(o_dmem_req); valid_cnt += int'(o_load_valid);
        @(negedge i_clk);
        #1 req_cnt += int'(o_dmem_req);
        i_step = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_reset = 1'b0;
        i_alu = 32'h10; i_mem_read = 1'b1; i_step = 1'b1; i_branch = 1'b1; i_zero = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if ({o_dmem_req, o_dmem_we, o_stall, o_pc_src, o_load_valid, o_misaligned, o_timeout} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {o_dmem_req, o_dmem_we, o_stall, o_pc_src, o_load_valid, o_misaligned, o_timeout});
        end
        checks++;
        if ({o_dmem_addr, o_dmem_wdata, o_load_data, o_dmem_be} !== '0) begin
            fails++;
            $display("FAIL reset_buses: addr %h wdata %h ld %h be %b, expected all zero",
                     o_dmem_addr, o_dmem_wdata, o_load_data, o_dmem_be);
        end
        @(negedge i_clk);
        i_mem_read = 1'b0; i_step = 1'b0; i_branch = 1'b0; i_zero = 1'b0;
        i_reset = 1'b1;
        model_ld = '0;
    endtask

    task automatic test_store_byte();
        int sc, rc, vc, qc; logic [3:0] be; logic [31:0] wd, ad; logic we;
        drive_access(1'b1, 32'h1002, 32'h0000_00A5, 32'h0, 2'b10, 1'b0, 0, sc, rc, be, wd, ad, we);
        checks++; if (be !== 4'b0100) begin fails++; $display("FAIL sb_be: got %b expected 0100", be); end
        checks++; if (wd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", wd); end
        checks++; if (we !== 1'b1) begin fails++; $display("FAIL sb_we: got %b expected 1", we); end
        checks++; if (ad !== 32'h1000) begin fails++; $display("FAIL sb_addr: got %h expected 00001000", ad); end
        checks++; if (sc != 2) begin fails++; $display("FAIL sb_stall_cycles: got %0d expected 2", sc); end
        checks++; if (o_load_data !== model_ld) begin fails++; $display("FAIL sb_load_unchanged: got %h expected %h", o_load_data, model_ld); end
        finish_done(0, vc, qc);
        checks++; if (vc != 1 || qc != 0) begin fails++; $display("FAIL sb_done: valid %0d req %0d expected 1 0", vc, qc); end
    endtask

    task automatic test_load_half();
        int sc, rc, vc, qc; logic [3:0] be; logic [31:0] wd, ad; logic we;
        for (int z = 0; z < 2; z++) begin
            drive_access(1'b0, 32'h2002, 32'h0, 32'h8001_1234, 2'b01, 1'(z), 0, sc, rc, be, wd, ad, we);
            model_ld = (z == 0) ? 32'hFFFF_8001 : 32'h0000_8001;
            #1;
            checks++; if (o_load_data !== model_ld) begin fails++; $display("FAIL lh_data_z%0d: got %h expected %h", z, o_load_data, model_ld); end
            checks++; if (o_load_valid !== 1'b1) begin fails++; $display("FAIL lh_valid_z%0d: got %b expected 1", z, o_load_valid); end
            checks++; if (be !== 4'hF || we !== 1'b0) begin fails++; $display("FAIL lh_be_we_z%0d: got %b/%b expected 1111/0", z, be, we); end
            finish_done(1, vc, qc);
        end
    endtask

    task automatic test_load_delayed();
        int sc, rc, vc, qc; logic [3:0] be; logic [31:0] wd, ad, rd; logic we;
        rd = $urandom;
        drive_access(1'b0, 32'h4000, 32'h0, rd, 2'b00, 1'b0, 3, sc, rc, be, wd, ad, we);
        model_ld = rd;
        checks++; if (rc != 4) begin fails++; $display("FAIL ld3_req_cycles: got %0d expected 4", rc); end
        checks++; if (sc != 5) begin fails++; $display("FAIL ld3_stall_cycles: got %0d expected 5", sc); end
        checks++; if (o_load_data !== rd) begin fails++; $display("FAIL ld3_data: got %h expected %h", o_load_data, rd); end
        finish_done(3, vc, qc);
        checks++; if (vc != 4) begin fails++; $display("FAIL ld3_done_hold: got %0d expected 4", vc); end
        checks++; if (qc != 0) begin fails++; $display("FAIL ld3_no_reissue: got %0d req cycles expected 0", qc); end
    endtask

    task automatic test_random();
        int sc, rc, vc, qc, dly; logic [3:0] be; logic [31:0] wd, ad, a, d, rd, exp_v; logic we;
        bit wr, zx; logic [1:0] sz;
        for (int t = 0; t < 24; t++) begin
            wr = 1'($urandom_range(0, 1)); zx = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); dly = $urandom_range(0, 4);
            a = $urandom; d = $urandom; rd = $urandom;
            if (sz == 2'b01) a = a - (a % 2);
            else if (sz != 2'b10) a = a - (a % 4);
            if (!wr) model_ld = m_load(rd, a, sz, zx);
            exp_q.push_back(model_ld);
            drive_access(wr, a, d, rd, sz, zx, dly, sc, rc, be, wd, ad, we);
            checks++; if (be !== m_be(wr, a, sz)) begin fails++; $display("FAIL rnd%0d_be: got %b expected %b", t, be, m_be(wr, a, sz)); end
            if (wr) begin
                checks++; if (wd !== m_wdata(d, sz)) begin fails++; $display("FAIL rnd%0d_wdata: got %h expected %h", t, wd, m_wdata(d, sz)); end
            end
            checks++; if (ad !== (a - (a % 4)) || we !== 1'(wr)) begin fails++; $display("FAIL rnd%0d_addr_we: got %h/%b expected %h/%b", t, ad, we, a - (a % 4), wr); end
            checks++; if (rc != dly + 1 || sc != dly + 2) begin fails++; $display("FAIL rnd%0d_cycles: req %0d stall %0d expected %0d %0d", t, rc, sc, dly + 1, dly + 2); end
            exp_v = exp_q.pop_front();
            checks++; if (o_load_data !== exp_v) begin fails++; $display("FAIL rnd%0d_load: got %h expected %h", t, o_load_data, exp_v); end
            finish_done($urandom_range(0, 2), vc, qc);
            checks++; if (qc != 0) begin fails++; $display("FAIL rnd%0d_reissue: got %0d req cycles expected 0", t, qc); end
        end
        checks++; if (o_misaligned !== 1'b0) begin fails++; $display("FAIL rnd_misaligned: got %b expected 0", o_misaligned); end
    endtask

    task automatic test_branch();
        bit b, n, z;
        @(negedge i_clk);
        for (int k = 0; k < 16; k++) begin
            if (k < 3) begin
                b = (k == 0); n = (k != 0); z = (k != 2);
            end else begin
                b = 1'($urandom_range(0, 1)); n = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
            end
            i_branch = b; i_neq_branch = n; i_zero = z;
            #1;
            checks++;
            if (o_pc_src !== 1'(m_pc(b, n, z))) begin
                fails++; $display("FAIL branch_%0d(b%0d n%0d z%0d): got %b expected %b", k, b, n, z, o_pc_src, m_pc(b, n, z));
            end
        end
        i_branch = 1'b0; i_neq_branch = 1'b0; i_zero = 1'b0;
    endtask

    task automatic test_misaligned();
        @(negedge i_clk);
        i_alu = 32'h3001; i_mem_read = 1'b1; i_mem_write = 1'b0; i_size_filterL = 2'b00; i_step = 1'b1;
        #1;
        checks++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin fails++; $display("FAIL mis_no_stall: stall %b req %b expected 0 0", o_stall, o_dmem_req); end
        @(negedge i_clk); #1;
        checks++; if (o_misaligned !== 1'b1 || o_dmem_req !== 1'b0) begin fails++; $display("FAIL mis_flag: flag %b req %b expected 1 0", o_misaligned, o_dmem_req); end
        i_mem_read = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++; if (o_misaligned !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b expected 1", o_misaligned); end
        i_step = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge i_clk);
        i_alu = 32'h5000; i_register_2 = $urandom; i_mem_write = 1'b1; i_size_filter = 2'b00; i_step = 1'b1;
        @(negedge i_clk);
        i_step = 1'b0;
        #1;
        checks++; if (o_dmem_req !== 1'b1) begin fails++; $display("FAIL rma_req_before: got %b expected 1", o_dmem_req); end
        #2 i_reset = 1'b0;
        #1;
        checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin fails++; $display("FAIL rma_req_async: req %b stall %b expected 0 0", o_dmem_req, o_stall); end
        checks++; if (o_misaligned !== 1'b0 || o_timeout !== 1'b0 || o_load_data !== 32'h0) begin fails++; $display("FAIL rma_flags: mis %b to %b ld %h expected 0 0 0", o_misaligned, o_timeout, o_load_data); end
        @(negedge i_clk);
        i_mem_write = 1'b0; i_reset = 1'b1;
        model_ld = '0;
        @(negedge i_clk); #1;
        checks++; if (o_dmem_req !== 1'b0) begin fails++; $display("FAIL rma_idle_after: req %b expected 0", o_dmem_req); end
    endtask

    task automatic test_timeout();
        int cnt;
        @(negedge i_clk);
        i_alu = 32'h6000; i_mem_read = 1'b1; i_mem_write = 1'b0; i_size_filterL = 2'b00;
        i_step = 1'b1; i_dmem_ack = 1'b0;
        @(negedge i_clk);
        i_step = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1 if (!o_dmem_req) break;
            cnt++;
            @(negedge i_clk);
        end
        checks++; if (cnt != 16) begin fails++; $display("FAIL to_access_cycles: got %0d expected 16", cnt); end
        checks++; if (o_timeout !== 1'b1 || o_stall !== 1'b1 || o_dmem_req !== 1'b0) begin fails++; $display("FAIL to_error_outs: to %b stall %b req %b expected 1 1 0", o_timeout, o_stall, o_dmem_req); end
        i_branch = 1'b1; i_zero = 1'b1; i_dmem_ack = 1'b1; i_dmem_rdata = $urandom;
        @(negedge i_clk); #1;
        checks++; if (o_pc_src !== 1'b0) begin fails++; $display("FAIL to_pc_src: got %b expected 0", o_pc_src); end
        checks++; if (o_timeout !== 1'b1 || o_load_valid !== 1'b0 || o_load_data !== model_ld) begin fails++; $display("FAIL to_ack_ignored: to %b valid %b ld %h expected 1 0 %h", o_timeout, o_load_valid, o_load_data, model_ld); end
        i_dmem_ack = 1'b0; i_branch = 1'b0; i_zero = 1'b0; i_mem_read = 1'b0;
        i_reset = 1'b0;
        #1;
        checks++; if (o_timeout !== 1'b0 || o_stall !== 1'b0) begin fails++; $display("FAIL to_reset_clear: to %b stall %b expected 0 0", o_timeout, o_stall); end
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_delayed();
        test_random();
        test_branch();
        test_misaligned();
        test_reset_mid_access();
        test_timeout();
        repeat (2) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline latch outputs. It turns latched memory controls, the ALU address and the store data into a req/ack transaction on the data-memory port. It aligns store data, generates byte enables, and extracts and extends load data. It stalls the pipeline while a transaction is outstanding and resolves beq/bne into the PC-select signal.

Parameters:
BITS_SIZE, 32, datapath and address width
TIMEOUT_CYCLES, 16, maximum cycles in ACCESS without ack before ERROR

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_step  in  1  pipeline advance enable (debug step / run)
i_alu  in  BITS_SIZE  byte address from EX/MEM
i_register_2  in  BITS_SIZE  store data
i_mem_read  in  1  load request
i_mem_write  in  1  store request
i_size_filter  in  2  store size: 00 word, 01 half, 10 byte, 11 treated as word
i_size_filterL  in  2  load size, same encoding
i_zero_extend  in  1  1 = zero-extend loads, 0 = sign-extend
i_branch  in  1  beq
i_neq_branch  in  1  bne
i_zero  in  1  ALU zero flag
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  BITS_SIZE  {i_alu[BITS_SIZE-1:2],2'b00}
o_dmem_wdata  out  BITS_SIZE  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  transaction complete; rdata valid same cycle
i_dmem_rdata  in  BITS_SIZE  read word
o_load_data  out  BITS_SIZE  extracted/extended load result (registered)
o_load_valid  out  1  high in DONE
o_stall  out  1  hold upstream latches
o_pc_src  out  1  branch taken
o_misaligned  out  1  sticky misaligned-access flag
o_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, i_reset=0): state IDLE, timeout counter 0, o_load_data 0, o_misaligned 0, o_timeout 0. All outputs low while in reset.
- Access pending = (i_mem_read | i_mem_write) & aligned. If both read and write are high, the access is a write.
- Alignment: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned. Size comes from i_size_filter for stores and i_size_filterL for loads.
- IDLE: o_stall = access pending & i_step. On an edge with i_step & access pending, go to ACCESS and clear the counter. i_step=0 means no access starts.
- Misaligned in IDLE with i_step: no request is issued; o_misaligned is set (sticky until reset); no stall; the pipeline proceeds.
- ACCESS: o_dmem_req=1 and o_stall=1. o_dmem_we, o_dmem_addr, o_dmem_wdata and o_dmem_be are driven combinationally from the held latch inputs.
  - On i_dmem_ack: register the load result into o_load_data (stores leave it unchanged) and go to DONE. Ack is accepted regardless of i_step.
  - Without ack: increment the counter. When counter = TIMEOUT_CYCLES-1 and still no ack, go to ERROR.
- DONE: o_load_valid=1, o_stall=0, o_dmem_req=0. Go to IDLE on an edge with i_step=1; otherwise hold DONE. The same instruction must not re-issue.
- ERROR: o_timeout=1, o_stall=1, o_dmem_req=0. Exit only by reset.
- Store lanes (little-endian):
  - byte: be = 1<<addr[1:0], wdata = {4{data[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}
  - word: be = 1111, wdata = data
  - Loads drive be=1111.
- Load extract: byte = rdata lane addr[1:0]; half = addr[1] ? rdata[31:16] : rdata[15:0]; word = rdata. Extension is selected by i_zero_extend.
- o_pc_src = (i_branch & i_zero) | (i_neq_branch & ~i_zero), combinational, forced 0 in ERROR.
- Ack while not in ACCESS is ignored.
- Reset during ACCESS: o_dmem_req drops immediately (asynchronously) and state returns to IDLE.

Test Plan:
- Store byte, addr 0x1002, data 0x000000A5, ack after 1 cycle -> o_dmem_be=0100, wdata=0xA5A5A5A5, we=1, addr=0x1000; stall high 2 cycles.
- Load half, addr 0x2002, rdata 0x80011234: sign-extend -> o_load_data=0xFFFF8001; with i_zero_extend=1 -> 0x00008001; o_load_valid in DONE.
- Load word with ack delayed 3 cycles -> req held 4 ACCESS cycles; DONE held while i_step=0, then IDLE; no second req.
- No ack, TIMEOUT_CYCLES=16 -> ERROR after 16 ACCESS cycles; o_timeout=1, stall stays 1, req 0, o_pc_src 0.
- Load word at 0x3001 -> no req, o_misaligned=1 sticky, no stall. Reset asserted mid-ACCESS -> req falls without a clock edge; all flags clear.
- Branch: i_branch=1, i_zero=1 -> o_pc_src=1; i_neq_branch=1, i_zero=1 -> 0; i_neq_branch=1, i_zero=0 -> 1.
